// File: rtl/parity_pkg.sv
// Shared types and sizing helpers for the sequential parity checker.
// Keeps the FSM encoding and chunk-count arithmetic in one place.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/parity_seq_chk.sv
// Multi-cycle parity generator/checker: reduces CHUNK_W bits per cycle,
// returns the flag over a result handshake and counts mismatches.
module parity_seq_chk
  import parity_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              odd_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_flag,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int NCHUNK = nchunk(DATA_W, CHUNK_W);
  localparam int IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
    $error("DATA_W must be a multiple of CHUNK_W");
  end

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              mode_q;
  logic              acc_q;
  logic [IDX_W-1:0]  idx_q;
  logic              live_q;
  logic              ov_q;
  logic              of_q;
  logic              oe_q;
  logic              accept;
  logic              consume;
  logic              chunk_par;

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready  = live_q & (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign consume   = ov_q & out_ready;
  assign chunk_par = ^data_q[idx_q*CHUNK_W +: CHUNK_W];

  assign out_valid = ov_q;
  assign out_flag  = of_q;
  assign out_err   = oe_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      live_q <= 1'b0;
    end else begin
      state  <= state_nx;
      live_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (idx_q == LAST) state_nx = DONE;
      DONE:    if (consume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      data_q <= in_data;
      par_q  <= in_par;
      mode_q <= odd_mode;
      acc_q  <= 1'b0;
      idx_q  <= '0;
    end else if (state == CALC) begin
      acc_q <= acc_q ^ chunk_par;
      if (idx_q != LAST) idx_q <= idx_q + 1'b1;
    end
  end

  // Result registers load on the first DONE cycle and hold after consume
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ov_q <= 1'b0;
      of_q <= 1'b0;
      oe_q <= 1'b0;
    end else if ((state == DONE) && !ov_q) begin
      ov_q <= 1'b1;
      of_q <= acc_q ^ mode_q;
      oe_q <= acc_q ^ mode_q ^ par_q;
    end else if (consume) begin
      ov_q <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (consume & oe_q),
    .clr     (clr_cnt),
    .q       (err_cnt)
  );

endmodule

// File: tb/tb_parity_seq_chk.sv
// Randomised self-checking bench for parity_seq_chk: a default instance
// and a single-chunk, 2-bit-counter instance share the same stimulus.
module tb_parity_seq_chk;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_par = 1'b0;
  logic        odd_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready, out_valid, out_flag, out_err;
  logic [7:0]  err_cnt;
  logic        in_ready2, out_valid2, out_flag2, out_err2;
  logic [1:0]  err_cnt2;

  int n_chk = 0;
  int n_fail = 0;
  int cnt1 = 0;
  int cnt2 = 0;

  parity_seq_chk #(.DATA_W(32), .CHUNK_W(8), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .odd_mode(odd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag), .out_err(out_err),
    .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  parity_seq_chk #(.DATA_W(32), .CHUNK_W(32), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_par(in_par), .odd_mode(odd_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_flag(out_flag2), .out_err(out_err2),
    .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_flag(input logic [31:0] d, input logic o);
    return logic'($countones(d) % 2) ^ o;
  endfunction

  task automatic send(input logic [31:0] d, input logic p, input logic o,
                      input int hold, input logic clr);
    logic ef, ee;
    int n, lat, lat2;
    ef = ref_flag(d, o);
    ee = ef ^ p;
    @(negedge clock);
    in_valid = 1'b1; in_data = d; in_par = p; odd_mode = o;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    check("accept_wait", 32'(n < 50), 32'd1);
    check("ready_pair", 32'(in_ready2), 32'(in_ready));
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    lat2 = out_valid2 ? 0 : -1;
    while (!out_valid && lat < 20) begin
      in_data = $urandom; in_par = 1'($urandom); odd_mode = 1'($urandom);
      check("busy_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
      lat++;
      if (out_valid2 && lat2 < 0) lat2 = lat;
    end
    check("latency", 32'(lat), 32'd5);
    check("latency_1chunk", 32'(lat2), 32'd2);
    check("flag", 32'(out_flag), 32'(ef));
    check("err", 32'(out_err), 32'(ee));
    check("flag_1chunk", 32'(out_flag2), 32'(ef));
    check("err_1chunk", 32'(out_err2), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clock);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_flag", 32'(out_flag), 32'(ef));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_cnt = clr;
    @(negedge clock);
    out_ready = 1'b0;
    clr_cnt = 1'b0;
    if (clr) begin
      cnt1 = 0; cnt2 = 0;
    end else if (ee) begin
      if (cnt1 < 255) cnt1++;
      if (cnt2 < 3) cnt2++;
    end
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_flag_hold", 32'(out_flag), 32'(ef));
    check("post_ready", 32'(in_ready), 32'd1);
    check("err_cnt", 32'(err_cnt), 32'(cnt1));
    check("err_cnt_sat2", 32'(err_cnt2), 32'(cnt2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_rel_ready", 32'(in_ready), 32'd1);

    send(32'h0000002D, 1'b0, 1'b0, 0, 1'b0);
    send(32'h0000002D, 1'b0, 1'b1, 0, 1'b0);
    send(32'hFFFFFFFF, 1'b1, 1'b0, 0, 1'b0);
    send(32'h01000000, 1'b0, 1'b0, 0, 1'b0);
    send(32'h80000001, 1'b0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 5; i++)
      send(32'h00000007, 1'b0, 1'b0, i % 2, 1'b0);
    send(32'h00000001, 1'b0, 1'b0, 0, 1'b1);

    @(negedge clock);
    in_valid = 1'b1; in_data = 32'h00000003; in_par = 1'b1; odd_mode = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_flag", 32'(out_flag), 32'd0);
    check("arst_err", 32'(out_err), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_cnt", 32'(err_cnt), 32'd0);
    check("arst_valid2", 32'(out_valid2), 32'd0);
    cnt1 = 0; cnt2 = 0;
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid || out_valid2) seen++;
    end
    out_ready = 1'b0;
    check("arst_no_result", 32'(seen), 32'd0);

    send(32'h0000002D, 1'b1, 1'b0, 1, 1'b0);
    for (int i = 0; i < 25; i++)
      send($urandom, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
